// File: rtl/seq_detect_pkg.sv
// Shared helpers for the serial pattern detector: state width and the
// KMP-style next-state table computed at elaboration time.
package seq_detect_pkg;

    localparam int MAX_PAT_LEN = 16;
    localparam int TBL_SW      = 5;
    localparam int TBL_W       = (MAX_PAT_LEN + 1) * 2 * TBL_SW;

    function automatic int state_width(input int plen);
        return $clog2(plen + 1);
    endfunction

    // The match state is the state whose index equals the pattern length.
    function automatic int match_state(input int plen);
        return plen;
    endfunction

    // Longest pattern prefix (at most plen) that is a suffix of the first m
    // pattern bits followed by b. pat[plen-1] is the first received bit.
    function automatic int kmp_next(input logic [MAX_PAT_LEN-1:0] pat, input int plen,
                                    input int m, input logic b);
        int   best;
        int   idx;
        logic ok;
        logic sb;
        best = 0;
        for (int l = 1; l <= MAX_PAT_LEN; l++) begin
            if (l <= m + 1 && l <= plen) begin
                ok = 1'b1;
                for (int t = 0; t < MAX_PAT_LEN; t++) begin
                    if (t < l) begin
                        idx = m + 1 - l + t;
                        if (idx == m) sb = b;
                        else          sb = pat[plen-1-idx];
                        if (sb != pat[plen-1-t]) ok = 1'b0;
                    end
                end
                if (ok) best = l;
            end
        end
        return best;
    endfunction

    // Entry (m, b) sits at [(m*2+b)*TBL_SW +: TBL_SW]; row plen is the
    // overlapping exit from the match state.
    function automatic logic [TBL_W-1:0] build_table(input logic [MAX_PAT_LEN-1:0] pat,
                                                     input int plen);
        logic [TBL_W-1:0] tbl;
        tbl = '0;
        for (int m = 0; m <= MAX_PAT_LEN; m++) begin
            for (int b = 0; b < 2; b++) begin
                if (m <= plen)
                    tbl[(m*2+b)*TBL_SW +: TBL_SW] = TBL_SW'(kmp_next(pat, plen, m, b == 1));
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/seq_detect_chan.sv
// One channel of the Moore pattern detector; hit counter present only when
// HIT_COUNTER_EN is defined.
module seq_detect_chan
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8,
    parameter int                 SW      = state_width(PAT_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             y,
    output logic [SW-1:0]    state_o,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [MAX_PAT_LEN-1:0] PAT_EXT  = MAX_PAT_LEN'(PATTERN);
    localparam logic [TBL_W-1:0]       NEXT_TBL = build_table(PAT_EXT, PAT_LEN);
    localparam logic [SW-1:0]          MATCH_ST = SW'(match_state(PAT_LEN));

    logic [SW-1:0]     state;
    logic [SW-1:0]     state_nxt;
    logic [SW-1:0]     tbl_row;
    logic [TBL_SW-1:0] tbl_entry;

    always_ff @(posedge clk) begin
        if (rst) state <= '0;
        else     state <= state_nxt;
    end

    // Leaving the match state without overlap behaves like a fresh start.
    always_comb begin
        tbl_row = state;
        if (state > MATCH_ST || (state == MATCH_ST && !overlap_en)) tbl_row = '0;
        tbl_entry = NEXT_TBL[{tbl_row, x} * TBL_SW +: TBL_SW];
        state_nxt = state;
        if (in_valid) state_nxt = (state > MATCH_ST) ? '0 : tbl_entry[SW-1:0];
    end

    always_comb begin
        y       = (state == MATCH_ST);
        state_o = state;
    end

`ifdef HIT_COUNTER_EN
    logic [CNT_W-1:0] cnt;
    logic             hit_entry;

    assign hit_entry = in_valid && (state_nxt == MATCH_ST);

    always_ff @(posedge clk) begin
        if (rst)                          cnt <= '0;
        else if (cnt_clr)                 cnt <= hit_entry ? CNT_W'(1) : '0;
        else if (hit_entry && cnt != '1)  cnt <= cnt + CNT_W'(1);
    end

    assign hit_cnt = cnt;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign hit_cnt        = '0;
`endif

endmodule

// File: rtl/seq_detect_multi.sv
// Multi-channel Moore serial-pattern detector. Define HIT_COUNTER_EN to add
// a saturating per-channel match counter.
module seq_detect_multi
    import seq_detect_pkg::*;
#(
    parameter int                 CHANNELS = 4,
    parameter int                 PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1011,
    parameter int                 CNT_W    = 8,
    localparam int                SW       = state_width(PAT_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [CHANNELS-1:0]       x,
    input  logic                      overlap_en,
    output logic [CHANNELS-1:0]       y,
    output logic [CHANNELS*SW-1:0]    state_o,
    input  logic                      cnt_clr,
    output logic [CHANNELS*CNT_W-1:0] hit_cnt
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        seq_detect_chan #(
            .PAT_LEN (PAT_LEN),
            .PATTERN (PATTERN),
            .CNT_W   (CNT_W),
            .SW      (SW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .x          (x[i]),
            .overlap_en (overlap_en),
            .cnt_clr    (cnt_clr),
            .y          (y[i]),
            .state_o    (state_o[i*SW +: SW]),
            .hit_cnt    (hit_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_seq_detect_multi.sv
// Bench for seq_detect_multi: directed vector table, corner sequences, and
// random traffic against a history-based reference model.
module tb_seq_detect_multi;

    localparam int CH = 4;
    localparam int P  = 4;
    localparam int CW = 8;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [CH-1:0]     x = '0;
    logic              overlap_en = 1'b0;
    logic              cnt_clr = 1'b0;
    logic [CH-1:0]     y;
    logic [CH*SW-1:0]  state_o;
    logic [CH*CW-1:0]  hit_cnt;

    logic [P-1:0] pat_v = 4'b1011;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_multi #(
        .CHANNELS (CH),
        .PAT_LEN  (P),
        .PATTERN  (4'b1011),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .x          (x),
        .overlap_en (overlap_en),
        .y          (y),
        .state_o    (state_o),
        .cnt_clr    (cnt_clr),
        .hit_cnt    (hit_cnt)
    );

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [CH-1:0] xi,
                         input logic ov, input logic clr);
        rst        = r;
        in_valid   = v;
        x          = xi;
        overlap_en = ov;
        cnt_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    // Reference model: remembers the bits seen since the last restart and
    // reports the longest pattern prefix that ends the history.
    bit hist[CH][$];
    int mst[CH];
    int mcnt[CH];

    function automatic int match_len(input bit q[$]);
        int  best;
        bit  ok;
        best = 0;
        for (int l = 1; l <= q.size(); l++) begin
            ok = 1'b1;
            for (int t = 0; t < l; t++)
                if (q[q.size()-l+t] != pat_v[P-1-t]) ok = 1'b0;
            if (ok) best = l;
        end
        return best;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [CH-1:0] xi,
                              input logic ov, input logic clr);
        bit entry;
        for (int i = 0; i < CH; i++) begin
            if (r) begin
                hist[i].delete();
                mst[i]  = 0;
                mcnt[i] = 0;
            end else begin
                entry = 1'b0;
                if (v) begin
                    if (mst[i] == P && !ov) hist[i].delete();
                    hist[i].push_back(xi[i]);
                    if (hist[i].size() > P) void'(hist[i].pop_front());
                    mst[i] = match_len(hist[i]);
                    entry  = (mst[i] == P);
                end
                if (clr)                                 mcnt[i] = entry ? 1 : 0;
                else if (entry && mcnt[i] < (1 << CW) - 1) mcnt[i]++;
            end
        end
    endtask

    typedef struct {
        logic             r;
        logic             v;
        logic [CH-1:0]    xi;
        logic             ov;
        logic [CH-1:0]    ey;
        logic [CH*SW-1:0] est;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input logic [CH-1:0] xi,
                                input logic ov, input int s0);
        vec_t e;
        e.r   = r;
        e.v   = v;
        e.xi  = xi;
        e.ov  = ov;
        e.ey  = (s0 == P) ? CH'(1) : '0;
        e.est = (CH*SW)'(s0);
        vecs.push_back(e);
    endfunction

    initial begin
        int               bits_a[7] = '{1, 0, 1, 1, 0, 1, 1};
        int               exp_ov1[7] = '{1, 2, 3, 4, 2, 3, 4};
        int               exp_ov0[7] = '{1, 2, 3, 4, 0, 1, 1};
        logic [CH-1:0]    ey;
        logic [CH*SW-1:0] est;
        logic [CH*CW-1:0] ehit;
        logic             r, v, ov, clr;
        logic [CH-1:0]    xi;

        // Reset, single match, overlap on/off, and holds while in_valid is low.
        add(1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) add(0, 1, CH'(bits_a[k]), 1, exp_ov1[k]);
        add(1, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) add(0, 1, CH'(bits_a[k]), 0, exp_ov0[k]);
        add(1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1);
        add(0, 1, 0, 0, 2);
        for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 2);
        add(0, 1, 1, 0, 3);
        add(0, 1, 1, 0, 4);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].xi, vecs[i].ov, 1'b0);
            chk($sformatf("tbl_y[%0d]", i), 64'(y), 64'(vecs[i].ey));
            chk($sformatf("tbl_state[%0d]", i), 64'(state_o), 64'(vecs[i].est));
            if (vecs[i].r) chk($sformatf("tbl_rst_hit[%0d]", i), 64'(hit_cnt), 64'(0));
        end

        // Reset in the middle of a pattern on channel 1.
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 4'b0010, 1, 0);
        drive(0, 1, 4'b0000, 1, 0);
        drive(0, 1, 4'b0010, 1, 0);
        chk("ch1_before_rst", 64'(state_o[5:3]), 64'(3));
        drive(1, 1, 4'b0010, 1, 0);
        chk("ch1_rst_state", 64'(state_o), 64'(0));
        chk("ch1_rst_y", 64'(y[1]), 64'(0));
        drive(0, 1, 4'b0010, 1, 0);
        chk("ch1_after_rst", 64'(state_o[5:3]), 64'(1));
        chk("ch1_after_rst_y", 64'(y), 64'(0));

`ifdef HIT_COUNTER_EN
        drive(1, 0, 0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 4; k++) drive(0, 1, CH'(bits_a[k]), 0, 0);
            if (n == 9) chk("hit_cnt_10", 64'(hit_cnt[7:0]), 64'(10));
        end
        chk("hit_cnt_sat", 64'(hit_cnt[7:0]), 64'(255));
        chk("hit_cnt_others", 64'(hit_cnt[CH*CW-1:8]), 64'(0));
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        chk("hit_cnt_hold_sat", 64'(hit_cnt[7:0]), 64'(255));
        drive(0, 1, 1, 0, 1);
        chk("hit_cnt_clr_entry", 64'(hit_cnt[7:0]), 64'(1));
        chk("hit_cnt_clr_entry_y", 64'(y[0]), 64'(1));
        drive(0, 0, 0, 0, 1);
        chk("hit_cnt_clr_only", 64'(hit_cnt), 64'(0));
`else
        chk("hit_cnt_absent", 64'(hit_cnt), 64'(0));
`endif

        // Random traffic against the reference model.
        model_edge(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        for (int c = 0; c < 2000; c++) begin
            r   = ($urandom_range(0, 63) == 0);
            v   = ($urandom_range(0, 3) != 0);
            xi  = CH'($urandom);
            ov  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 31) == 0);
            model_edge(r, v, xi, ov, clr);
            drive(r, v, xi, ov, clr);
            for (int i = 0; i < CH; i++) begin
                ey[i]            = (mst[i] == P);
                est[i*SW +: SW]  = SW'(mst[i]);
`ifdef HIT_COUNTER_EN
                ehit[i*CW +: CW] = CW'(mcnt[i]);
`else
                ehit[i*CW +: CW] = '0;
`endif
            end
            chk($sformatf("rnd_y[%0d]", c), 64'(y), 64'(ey));
            chk($sformatf("rnd_state[%0d]", c), 64'(state_o), 64'(est));
            chk($sformatf("rnd_hit[%0d]", c), 64'(hit_cnt), 64'(ehit));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
